// File: rtl/vga_timing.sv
// 800x600 @ 60 Hz raster timing: pixel/line counters plus sync and blanking flags,
// all registered so every output describes the same pixel in the same cycle.
module vga_timing #(
  parameter int unsigned HCOUNT_MAX  = 1056,
  parameter int unsigned VCOUNT_MAX  = 628,
  parameter int unsigned HBLNK_START = 800,
  parameter int unsigned HBLNK_STOP  = 1055,
  parameter int unsigned HSYNC_START = 840,
  parameter int unsigned HSYNC_STOP  = 967,
  parameter int unsigned VBLNK_START = 600,
  parameter int unsigned VBLNK_STOP  = 627,
  parameter int unsigned VSYNC_START = 601,
  parameter int unsigned VSYNC_STOP  = 604
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        hsync,
  output logic        hblnk,
  output logic        vsync,
  output logic        vblnk,
  output logic [11:0] rgb
);

  localparam logic [10:0] HLast      = 11'(HCOUNT_MAX - 1);
  localparam logic [10:0] VLast      = 11'(VCOUNT_MAX - 1);
  localparam logic [10:0] HBlnkStart = 11'(HBLNK_START);
  localparam logic [10:0] HBlnkStop  = 11'(HBLNK_STOP);
  localparam logic [10:0] HSyncStart = 11'(HSYNC_START);
  localparam logic [10:0] HSyncStop  = 11'(HSYNC_STOP);
  localparam logic [10:0] VBlnkStart = 11'(VBLNK_START);
  localparam logic [10:0] VBlnkStop  = 11'(VBLNK_STOP);
  localparam logic [10:0] VSyncStart = 11'(VSYNC_START);
  localparam logic [10:0] VSyncStop  = 11'(VSYNC_STOP);

  logic [10:0] hcount_d, hcount_q;
  logic [10:0] vcount_d, vcount_q;
  logic        hsync_d, hsync_q;
  logic        hblnk_d, hblnk_q;
  logic        vsync_d, vsync_q;
  logic        vblnk_d, vblnk_q;

  always_comb begin
    hcount_d = hcount_q + 11'd1;
    vcount_d = vcount_q;
    if (hcount_q == HLast) begin
      hcount_d = '0;
      vcount_d = (vcount_q == VLast) ? 11'd0 : vcount_q + 11'd1;
    end
  end

  // Flags decode the next counts so the registered flags line up with the registered counts.
  always_comb begin
    hsync_d = (hcount_d >= HSyncStart) && (hcount_d <= HSyncStop);
    hblnk_d = (hcount_d >= HBlnkStart) && (hcount_d <= HBlnkStop);
    vsync_d = (vcount_d >= VSyncStart) && (vcount_d <= VSyncStop);
    vblnk_d = (vcount_d >= VBlnkStart) && (vcount_d <= VBlnkStop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount_q <= '0;
      vcount_q <= '0;
      hsync_q  <= 1'b0;
      hblnk_q  <= 1'b0;
      vsync_q  <= 1'b0;
      vblnk_q  <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hsync_q  <= hsync_d;
      hblnk_q  <= hblnk_d;
      vsync_q  <= vsync_d;
      vblnk_q  <= vblnk_d;
    end
  end

  assign hcount = hcount_q;
  assign vcount = vcount_q;
  assign hsync  = hsync_q;
  assign hblnk  = hblnk_q;
  assign vsync  = vsync_q;
  assign vblnk  = vblnk_q;
  assign rgb    = 12'h000;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: a full-size instance for reset and horizontal decode, and a
// shrunken-raster instance so whole frames (vertical decode, wrap, repeat) fit in a short run.
module tb_vga_timing;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [10:0] d_hcount, d_vcount;
  logic        d_hsync, d_hblnk, d_vsync, d_vblnk;
  logic [11:0] d_rgb;
  logic [10:0] s_hcount, s_vcount;
  logic        s_hsync, s_hblnk, s_vsync, s_vblnk;
  logic [11:0] s_rgb;

  always #5 clk = ~clk;

  vga_timing u_dut (
    .clk    (clk),
    .rst    (rst),
    .hcount (d_hcount),
    .vcount (d_vcount),
    .hsync  (d_hsync),
    .hblnk  (d_hblnk),
    .vsync  (d_vsync),
    .vblnk  (d_vblnk),
    .rgb    (d_rgb)
  );

  // Small raster: 40 x 30, hblnk 30..39, hsync 32..35, vblnk 24..29, vsync 25..27.
  vga_timing #(
    .HCOUNT_MAX  (40),
    .VCOUNT_MAX  (30),
    .HBLNK_START (30),
    .HBLNK_STOP  (39),
    .HSYNC_START (32),
    .HSYNC_STOP  (35),
    .VBLNK_START (24),
    .VBLNK_STOP  (29),
    .VSYNC_START (25),
    .VSYNC_STOP  (27)
  ) u_small (
    .clk    (clk),
    .rst    (rst),
    .hcount (s_hcount),
    .vcount (s_vcount),
    .hsync  (s_hsync),
    .hblnk  (s_hblnk),
    .vsync  (s_vsync),
    .vblnk  (s_vblnk),
    .rgb    (s_rgb)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int dh = 0, dv = 0;  // expected position of u_dut
  int sh = 0, sv = 0;  // expected position of u_small

  // One clock: advance both position trackers on the rising edge, return at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (dh == 1055) begin
      dh = 0;
      dv = (dv == 627) ? 0 : dv + 1;
    end else begin
      dh = dh + 1;
    end
    if (sh == 39) begin
      sh = 0;
      sv = (sv == 29) ? 0 : sv + 1;
    end else begin
      sh = sh + 1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({d_hcount, d_vcount, d_hsync, d_hblnk, d_vsync, d_vblnk, d_rgb} !== 38'd0) begin
        n_bad++;
        $display("FAIL reset_hold_full cyc=%0d got h=%0d v=%0d hs=%b hb=%b vs=%b vb=%b rgb=%h want all 0",
                 i, d_hcount, d_vcount, d_hsync, d_hblnk, d_vsync, d_vblnk, d_rgb);
      end
      n_cmp++;
      if ({s_hcount, s_vcount, s_hsync, s_hblnk, s_vsync, s_vblnk, s_rgb} !== 38'd0) begin
        n_bad++;
        $display("FAIL reset_hold_small cyc=%0d got h=%0d v=%0d want all 0", i, s_hcount, s_vcount);
      end
    end
    rst = 1'b1;
    dh = 0; dv = 0; sh = 0; sv = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_cmp++;
      if (d_hcount !== 11'(k) || d_vcount !== 11'd0) begin
        n_bad++;
        $display("FAIL release_count got h=%0d v=%0d want h=%0d v=0", d_hcount, d_vcount, k);
      end
      n_cmp++;
      if (s_hcount !== 11'(k) || s_vcount !== 11'd0) begin
        n_bad++;
        $display("FAIL release_count_small got h=%0d v=%0d want h=%0d v=0", s_hcount, s_vcount, k);
      end
    end
  endtask

  task automatic test_hdecode();
    int          pts    [8] = '{799, 800, 839, 840, 967, 968, 1055, 0};
    bit          exp_hs [8] = '{0, 0, 0, 1, 1, 0, 0, 0};
    bit          exp_hb [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    logic [10:0] prev_v;
    int          guard = 0;
    while (dh != 790 && guard < 1100) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (dh != 790) begin
      n_bad++;
      $display("FAIL hdecode_align got h=%0d want 790", dh);
    end
    prev_v = d_vcount;
    for (int c = 0; c < 300; c++) begin
      tick();
      n_cmp++;
      if (d_hcount !== 11'(dh) || d_vcount !== 11'(dv)) begin
        n_bad++;
        $display("FAIL hcount_track got h=%0d v=%0d want h=%0d v=%0d", d_hcount, d_vcount, dh, dv);
      end
      n_cmp++;
      if (d_hsync !== (dh >= 840 && dh <= 967) || d_hblnk !== (dh >= 800 && dh <= 1055)) begin
        n_bad++;
        $display("FAIL hflag_rule h=%0d got hs=%b hb=%b", dh, d_hsync, d_hblnk);
      end
      n_cmp++;
      if (d_vcount !== prev_v && d_hcount !== 11'd0) begin
        n_bad++;
        $display("FAIL vcount_step got v=%0d at h=%0d want change only at h=0", d_vcount, d_hcount);
      end
      for (int j = 0; j < 8; j++) begin
        if (dh == pts[j]) begin
          n_cmp++;
          if (d_hsync !== exp_hs[j] || d_hblnk !== exp_hb[j]) begin
            n_bad++;
            $display("FAIL hpoint h=%0d got hs=%b hb=%b want hs=%b hb=%b",
                     pts[j], d_hsync, d_hblnk, exp_hs[j], exp_hb[j]);
          end
        end
      end
      if (dh == 0) begin
        n_cmp++;
        if (d_vcount !== 11'd1) begin
          n_bad++;
          $display("FAIL line_wrap_vcount got v=%0d want 1", d_vcount);
        end
      end
      prev_v = d_vcount;
    end
  endtask

  task automatic test_frame();
    int          vpts [6] = '{23, 24, 25, 27, 28, 29};
    bit          exp_vs [6] = '{0, 0, 1, 1, 0, 0};
    bit          exp_vb [6] = '{0, 1, 1, 1, 1, 1};
    logic [25:0] sig1 [1200];
    logic [25:0] sig;
    logic [10:0] prev_h, prev_v;
    int          guard = 0;
    while (!(sh == 0 && sv == 0) && guard < 1300) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (!(sh == 0 && sv == 0)) begin
      n_bad++;
      $display("FAIL frame_align got h=%0d v=%0d want 0,0", sh, sv);
    end
    prev_h = s_hcount;
    prev_v = s_vcount;
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 1200; c++) begin
        sig = {s_hcount, s_vcount, s_hsync, s_hblnk, s_vsync, s_vblnk};
        n_cmp++;
        if (s_hcount !== 11'(sh) || s_vcount !== 11'(sv)) begin
          n_bad++;
          $display("FAIL small_track got h=%0d v=%0d want h=%0d v=%0d", s_hcount, s_vcount, sh, sv);
        end
        n_cmp++;
        if (s_hsync !== (sh >= 32 && sh <= 35) || s_hblnk !== (sh >= 30 && sh <= 39) ||
            s_vsync !== (sv >= 25 && sv <= 27) || s_vblnk !== (sv >= 24 && sv <= 29) ||
            s_rgb !== 12'h000) begin
          n_bad++;
          $display("FAIL flag_rule h=%0d v=%0d got hs=%b hb=%b vs=%b vb=%b rgb=%h",
                   sh, sv, s_hsync, s_hblnk, s_vsync, s_vblnk, s_rgb);
        end
        if (c > 0 || f > 0) begin
          n_cmp++;
          if (s_vcount !== prev_v && !(prev_h == 11'd39 && s_hcount == 11'd0)) begin
            n_bad++;
            $display("FAIL vcount_step_small got v=%0d after h=%0d want change only on 39->0",
                     s_vcount, prev_h);
          end
        end
        if (sh == 0) begin
          for (int j = 0; j < 6; j++) begin
            if (sv == vpts[j]) begin
              n_cmp++;
              if (s_vsync !== exp_vs[j] || s_vblnk !== exp_vb[j]) begin
                n_bad++;
                $display("FAIL vpoint v=%0d got vs=%b vb=%b want vs=%b vb=%b",
                         vpts[j], s_vsync, s_vblnk, exp_vs[j], exp_vb[j]);
              end
            end
          end
        end
        if (f == 1 && c == 0) begin
          n_cmp++;
          if (prev_h !== 11'd39 || prev_v !== 11'd29 || s_hcount !== 11'd0 ||
              s_vcount !== 11'd0 || s_hblnk !== 1'b0 || s_vblnk !== 1'b0) begin
            n_bad++;
            $display("FAIL frame_wrap got (%0d,%0d)->(%0d,%0d) hb=%b vb=%b want (39,29)->(0,0) 0 0",
                     prev_h, prev_v, s_hcount, s_vcount, s_hblnk, s_vblnk);
          end
        end
        if (f == 0) begin
          sig1[c] = sig;
        end else begin
          n_cmp++;
          if (sig !== sig1[c]) begin
            n_bad++;
            $display("FAIL frame_repeat cyc=%0d got %h want %h", c, sig, sig1[c]);
          end
        end
        prev_h = s_hcount;
        prev_v = s_vcount;
        tick();
      end
    end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    while (!(sh == 20 && sv == 15) && guard < 1300) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (!(sh == 20 && sv == 15) || s_hcount !== 11'd20 || s_vcount !== 11'd15) begin
      n_bad++;
      $display("FAIL async_align got h=%0d v=%0d want 20,15", s_hcount, s_vcount);
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({s_hcount, s_vcount, s_hsync, s_hblnk, s_vsync, s_vblnk, s_rgb} !== 38'd0) begin
      n_bad++;
      $display("FAIL async_clear_small got h=%0d v=%0d want 0,0 before edge", s_hcount, s_vcount);
    end
    n_cmp++;
    if ({d_hcount, d_vcount, d_hsync, d_hblnk, d_vsync, d_vblnk, d_rgb} !== 38'd0) begin
      n_bad++;
      $display("FAIL async_clear_full got h=%0d v=%0d want 0,0 before edge", d_hcount, d_vcount);
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({s_hcount, s_vcount, d_hcount, d_vcount} !== 44'd0) begin
      n_bad++;
      $display("FAIL async_hold got sh=%0d sv=%0d dh=%0d dv=%0d want 0", s_hcount, s_vcount,
               d_hcount, d_vcount);
    end
    rst = 1'b1;
    dh = 0; dv = 0; sh = 0; sv = 0;
    tick();
    n_cmp++;
    if (s_hcount !== 11'd1 || s_vcount !== 11'd0 || d_hcount !== 11'd1 || d_vcount !== 11'd0) begin
      n_bad++;
      $display("FAIL async_restart got sh=%0d sv=%0d dh=%0d dv=%0d want 1,0,1,0",
               s_hcount, s_vcount, d_hcount, d_vcount);
    end
    for (int c = 0; c < 1200; c++) begin
      tick();
      n_cmp++;
      if (s_hcount !== 11'(sh) || s_vcount !== 11'(sv) || s_vblnk !== (sv >= 24 && sv <= 29) ||
          s_hblnk !== (sh >= 30 && sh <= 39)) begin
        n_bad++;
        $display("FAIL post_reset_track got h=%0d v=%0d hb=%b vb=%b want h=%0d v=%0d",
                 s_hcount, s_vcount, s_hblnk, s_vblnk, sh, sv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hdecode();
    test_frame();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
